// File: rtl/prach_pkg.sv
// PRACH halfband interpolator shared constants.
//   NumChannelUsed : active TDM channel slots per frame (delay-line tap spacing)
//   Latency        : din_dv to dout_dv delay in cycles (data and sideband)
//   hb_coef()      : unique halfband coefficients, fi(1,18,17), gain 2 folded in
//   RoundConst     : round-half-up constant for the 17-bit output shift
package prach_pkg;

   localparam int unsigned NumChannelUsed = 48;
   localparam int unsigned Latency        = 6;
   localparam int unsigned DataWidth      = 16;
   localparam int unsigned CoefWidth      = 18;
   localparam int unsigned PreWidth       = DataWidth + 1;
   localparam int unsigned ProdWidth      = PreWidth + CoefWidth;
   localparam int unsigned AccWidth       = ProdWidth + 2;
   localparam int unsigned OutShift       = CoefWidth - 1;

   typedef logic signed [CoefWidth-1:0] coef_t;
   typedef logic signed [AccWidth-1:0]  acc_t;

   localparam acc_t RoundConst = acc_t'(65536);

   // Symmetric filter: coefficient k applies to taps k and 7-k.
   function automatic coef_t hb_coef(input logic [1:0] k);
      unique case (k)
         2'd0:    return coef_t'(-1338);
         2'd1:    return coef_t'(6198);
         2'd2:    return coef_t'(-19878);
         default: return coef_t'(80462);
      endcase
   endfunction

endpackage

// File: rtl/prach_delay.sv
// Generic fixed delay line with asynchronous active-low reset.
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : WIDTH-bit input word
//   dout       : din delayed by DELAY cycles (DELAY >= 1)
module prach_delay #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DELAY = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe_q [DELAY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= din;
         for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign dout = pipe_q[DELAY-1];

endmodule

// File: rtl/prach_hb4_interp.sv
// Halfband interpolate-by-2 stage for the PRACH TDM channel stream.
//   clk, rst_n         : clock, asynchronous active-low reset
//   din_dq, din_dv     : input sample fi(1,16,15) and its valid
//   din_chn, sync_in   : sideband, delayed untouched
//   dout_dp1           : phase 0, x[n-3] passed through
//   dout_dp2           : phase 1, interpolated mid-sample (precedes dp1 in time)
//   dout_dv, dout_chn, sync_out : sideband delayed by Latency cycles
module prach_hb4_interp
   import prach_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [DataWidth-1:0] din_dq,
   input  logic                        din_dv,
   input  logic [7:0]                  din_chn,
   input  logic                        sync_in,
   output logic signed [DataWidth-1:0] dout_dp1,
   output logic signed [DataWidth-1:0] dout_dp2,
   output logic                        dout_dv,
   output logic [7:0]                  dout_chn,
   output logic                        sync_out
);

   localparam int unsigned Taps     = 8;
   localparam int unsigned Half     = Taps / 2;
   localparam int unsigned ShrWidth = AccWidth - OutShift;
   // Entries past the last tap would never be read, so the line stops at xd[7C].
   localparam int unsigned XdLen    = (Taps - 1) * NumChannelUsed + 1;

   typedef logic signed [DataWidth-1:0] smp_t;
   typedef logic signed [PreWidth-1:0]  pre_t;
   typedef logic signed [ProdWidth-1:0] prod_t;
   typedef logic signed [ShrWidth-1:0]  shr_t;

   localparam shr_t SatMax = shr_t'(32767);
   localparam shr_t SatMin = shr_t'(-32768);

   // Channel delay line: no reset so it can map onto shift-register primitives.
   smp_t xd [XdLen];

   always_ff @(posedge clk) begin
      if (din_dv) begin
         xd[0] <= din_dq;
         for (int i = 1; i < XdLen; i++) xd[i] <= xd[i-1];
      end
   end

   smp_t       tap_q [Taps];
   pre_t       pre_q [Half];
   prod_t      prod_q [Half];
   acc_t       acc_q;
   smp_t       dp1_pre_q, dp1_mul_q, dp1_sum_q;
   // Valid tag riding alongside the datapath; idle slots leave zeros on the outputs.
   logic [4:0] vld_q;

   shr_t shr;
   smp_t sat;

   always_comb begin
      shr = shr_t'((acc_q + RoundConst) >>> OutShift);
      if (shr > SatMax) begin
         sat = smp_t'(SatMax);
      end else if (shr < SatMin) begin
         sat = smp_t'(SatMin);
      end else begin
         sat = smp_t'(shr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < Taps; k++) tap_q[k] <= '0;
         for (int k = 0; k < Half; k++) begin
            pre_q[k]  <= '0;
            prod_q[k] <= '0;
         end
         acc_q     <= '0;
         dp1_pre_q <= '0;
         dp1_mul_q <= '0;
         dp1_sum_q <= '0;
         vld_q     <= '0;
         dout_dp1  <= '0;
         dout_dp2  <= '0;
      end else begin
         vld_q <= {vld_q[3:0], din_dv};
         for (int k = 0; k < Taps; k++) tap_q[k] <= xd[k*NumChannelUsed];
         for (int k = 0; k < Half; k++) begin
            pre_q[k]  <= pre_t'(tap_q[k]) + pre_t'(tap_q[Taps-1-k]);
            prod_q[k] <= prod_t'(pre_q[k]) * prod_t'(hb_coef(2'(k)));
         end
         acc_q <= acc_t'(prod_q[0]) + acc_t'(prod_q[1]) + acc_t'(prod_q[2]) + acc_t'(prod_q[3]);
         dp1_pre_q <= tap_q[3];
         dp1_mul_q <= dp1_pre_q;
         dp1_sum_q <= dp1_mul_q;
         dout_dp1  <= vld_q[4] ? dp1_sum_q : '0;
         dout_dp2  <= vld_q[4] ? sat : '0;
      end
   end

   logic [9:0] sb_out;

   prach_delay #(
      .WIDTH (10),
      .DELAY (Latency)
   ) u_sideband (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({sync_in, din_dv, din_chn}),
      .dout  (sb_out)
   );

   assign {sync_out, dout_dv, dout_chn} = sb_out;

endmodule

// File: tb/tb_prach_hb4_interp.sv
module tb_prach_hb4_interp;

   localparam int C = 48;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [15:0] din_dq = '0;
   logic               din_dv = 1'b0;
   logic [7:0]         din_chn = '0;
   logic               sync_in = 1'b0;
   logic signed [15:0] dout_dp1, dout_dp2;
   logic               dout_dv;
   logic [7:0]         dout_chn;
   logic               sync_out;

   prach_hb4_interp dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din_dq   (din_dq),
      .din_dv   (din_dv),
      .din_chn  (din_chn),
      .sync_in  (sync_in),
      .dout_dp1 (dout_dp1),
      .dout_dp2 (dout_dp2),
      .dout_dv  (dout_dv),
      .dout_chn (dout_chn),
      .sync_out (sync_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic dv;
      int   chn;
      logic sy;
      int   m;
      int   dp1;
      int   dp2;
      bit   cd;
      bit   strict;
   } exp_t;

   typedef struct {
      string name;
      int    m;
      int    dp1;
      int    dp2;
   } vec_t;

   exp_t expq[$];
   vec_t tbl[$];
   int   samp [8192];
   int   cap1 [8192];
   int   cap2 [8192];
   bit   capv [8192];
   int   m_in = 0;
   int   checks = 0;
   int   failures = 0;
   int   sync_seen = 0;
   bit   chk_data = 1'b0;
   bit   strict_mode = 1'b0;
   int   coef [4] = '{-1338, 6198, -19878, 80462};
   int   imp2 [8] = '{-167, 775, -2485, 10058, 10058, -2485, 775, -167};
   int   pat [8]  = '{-32768, 32767, -32768, 32767, 32767, -32768, 32767, -32768};

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int xs(input int m);
      return (m < 0) ? 0 : samp[m];
   endfunction

   // Plain halfband arithmetic on the per-channel history x[n-k] = sample m-k*C.
   function automatic int model_dp2(input int m);
      longint y = 0;
      for (int k = 0; k < 8; k++) y += longint'(coef[(k < 4) ? k : 7 - k]) * xs(m - k * C);
      y = (y + 65536) >>> 17;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      return int'(y);
   endfunction

   function automatic int rnd16();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic compare_front();
      exp_t e;
      if (expq.size() < 6) return;
      e = expq.pop_front();
      chk("dout_dv", dout_dv, e.dv);
      chk("dout_chn", dout_chn, e.chn);
      chk("sync_out", sync_out, e.sy);
      if (sync_out === 1'b1) sync_seen++;
      if (e.dv) begin
         cap1[e.m] = int'($signed(dout_dp1));
         cap2[e.m] = int'($signed(dout_dp2));
         capv[e.m] = 1'b1;
         if (e.cd) begin
            chk($sformatf("dp1[m=%0d]", e.m), $signed(dout_dp1), e.dp1);
            chk($sformatf("dp2[m=%0d]", e.m), $signed(dout_dp2), e.dp2);
         end
      end else if (e.strict) begin
         chk("dp1_after_reset", $signed(dout_dp1), 0);
         chk("dp2_after_reset", $signed(dout_dp2), 0);
      end
   endtask

   // Inputs change at the falling edge, outputs are checked at the next falling edge.
   task automatic step(input logic dv, input int d, input int chn, input logic sy);
      exp_t e;
      din_dv  = dv;
      din_dq  = 16'(d);
      din_chn = 8'(chn);
      sync_in = sy;
      e.dv = dv; e.chn = chn & 255; e.sy = sy; e.m = -1; e.dp1 = 0; e.dp2 = 0;
      e.cd = chk_data; e.strict = strict_mode;
      if (dv) begin
         samp[m_in] = d;
         e.m   = m_in;
         e.dp1 = xs(m_in - 3 * C);
         e.dp2 = model_dp2(m_in);
         m_in++;
      end
      @(posedge clk);
      expq.push_back(e);
      @(negedge clk);
      compare_front();
   endtask

   task automatic vstep(input int d, input logic sy = 1'b0, input int chn = -1);
      step(1'b1, d, (chn < 0) ? (m_in % C) : chn, sy);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_dv"}, dout_dv, 0);
      chk({tag, "_dp1"}, $signed(dout_dp1), 0);
      chk({tag, "_dp2"}, $signed(dout_dp2), 0);
      chk({tag, "_chn"}, dout_chn, 0);
      chk({tag, "_sync"}, sync_out, 0);
   endtask

   task automatic restart_after_reset();
      exp_t z;
      z.dv = 1'b0; z.chn = 0; z.sy = 1'b0; z.m = -1; z.dp1 = 0; z.dp2 = 0;
      z.cd = 1'b0; z.strict = 1'b1;
      expq.delete();
      for (int i = 0; i < 5; i++) expq.push_back(z);
   endtask

   initial begin
      int nvalid;

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      restart_after_reset();

      // Flush stale delay-line contents with 8 frames of zeros
      chk_data = 1'b0;
      for (int i = 0; i < 8 * C; i++) vstep(0);
      chk_data = 1'b1;

      // Impulse on channel 0 (base m=384)
      for (int i = 0; i < 8 * C; i++) vstep((i == 0) ? 16384 : 0);
      // DC (base m=768)
      for (int i = 0; i < 8 * C; i++) vstep(32767);
      // Saturation on channel 2, then sign-flipped (bases m=1152, m=1536)
      for (int f = 0; f < 8; f++)
         for (int ch = 0; ch < C; ch++) vstep((ch == 2) ? pat[f] : rnd16());
      for (int f = 0; f < 8; f++)
         for (int ch = 0; ch < C; ch++) vstep((ch == 2) ? ((pat[f] == 32767) ? -32768 : 32767)
                                                        : rnd16());

      // Lone sync pulse with din_chn=5
      for (int i = 0; i < 3; i++) vstep(rnd16());
      vstep(rnd16(), 1'b1, 5);
      for (int i = 0; i < 8; i++) vstep(rnd16());

      // Random stream with ~30% idle cycles
      nvalid = 0;
      while (nvalid < 10 * C) begin
         if ($urandom_range(0, 99) < 30) begin
            step(1'b0, rnd16(), int'($urandom_range(0, 255)), 1'b0);
         end else begin
            vstep(rnd16());
            nvalid++;
         end
      end

      // Mid-frame reset
      for (int i = 0; i < 7; i++) vstep(rnd16());
      din_dv = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_all_zero("rst_async");
      repeat (2) @(negedge clk);
      check_all_zero("rst_hold");
      rst_n = 1'b1;
      restart_after_reset();
      strict_mode = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b0);
      strict_mode = 1'b0;
      for (int i = 0; i < 2 * C; i++) vstep(rnd16());
      for (int i = 0; i < 6; i++) step(1'b0, 0, 0, 1'b0);

      // Explicit spot values
      for (int f = 0; f < 8; f++)
         tbl.push_back('{"imp_ch0", 384 + f * C, (f == 3) ? 16384 : 0, imp2[f]});
      tbl.push_back('{"imp_ch1", 384 + 1, 0, 0});
      tbl.push_back('{"imp_ch47", 384 + 3 * C + 47, 0, 0});
      tbl.push_back('{"imp_ch5", 384 + 7 * C + 5, 0, 0});
      tbl.push_back('{"dc_ch0", 768 + 7 * C, 32767, 32721});
      tbl.push_back('{"dc_ch1", 768 + 7 * C + 1, 32767, 32721});
      tbl.push_back('{"dc_ch47", 768 + 7 * C + 47, 32767, 32721});
      tbl.push_back('{"dc_last", 768 + 8 * C - 1, 32767, 32721});
      tbl.push_back('{"sat_pos", 1152 + 7 * C + 2, 32767, 32767});
      tbl.push_back('{"sat_neg", 1536 + 7 * C + 2, -32768, -32768});
      for (int i = 0; i < tbl.size(); i++) begin
         if (!capv[tbl[i].m]) begin
            chk({tbl[i].name, "_captured"}, 0, 1);
         end else begin
            chk({tbl[i].name, "_dp1"}, cap1[tbl[i].m], tbl[i].dp1);
            chk({tbl[i].name, "_dp2"}, cap2[tbl[i].m], tbl[i].dp2);
         end
      end
      chk("sync_out_pulses", sync_seen, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
